// File: rtl/shift_deserializer_if.sv
// Bundles the serial input, the parallel output handshake and the status flags
// of the shift deserializer.
interface shift_deserializer_if #(
   parameter int N = 4
);
   logic         frame_start;
   logic         sin;
   logic         sin_valid;
   logic [N-1:0] dout;
   logic         dout_valid;
   logic         dout_ready;
   logic         busy;
   logic         overrun;

   modport master (
      output frame_start, sin, sin_valid, dout_ready,
      input  dout, dout_valid, busy, overrun
   );

   modport slave (
      input  frame_start, sin, sin_valid, dout_ready,
      output dout, dout_valid, busy, overrun
   );
endinterface

// File: rtl/shift_deserializer.sv
// Serial-to-parallel converter: collects N framed bits into a word and offers it
// through a one-entry valid/ready output register with a sticky overrun flag.
module shift_deserializer #(
   parameter int N         = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   shift_deserializer_if.slave bus
);
   localparam int CW = $clog2(N);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d, cnt_base;
   logic [N-1:0]    sreg_q, sreg_d, sreg_shift;
   logic [N-1:0]    dout_q, dout_d;
   logic            dout_valid_q, dout_valid_d;
   logic            overrun_q, overrun_d;
   logic            sample, complete, load;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         sreg_q       <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         sreg_q       <= sreg_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         overrun_q    <= overrun_d;
      end
   end

   // frame_start restarts the count and lets a same-cycle sin be bit 0 of the new frame
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      sreg_d       = sreg_q;
      dout_d       = dout_q;
      dout_valid_d = dout_valid_q;
      overrun_d    = overrun_q;

      cnt_base   = bus.frame_start ? '0 : cnt_q;
      sample     = bus.sin_valid && (bus.frame_start || state_q == SHIFT);
      sreg_shift = MSB_FIRST ? {sreg_q[N-2:0], bus.sin} : {bus.sin, sreg_q[N-1:1]};
      complete   = sample && (cnt_base == CW'(N-1));
      load       = complete && (!dout_valid_q || bus.dout_ready);

      if (bus.frame_start) begin
         state_d = SHIFT;
      end else if (complete) begin
         state_d = IDLE;
      end

      cnt_d = cnt_base;
      if (sample) begin
         sreg_d = sreg_shift;
         cnt_d  = complete ? '0 : cnt_base + CW'(1);
      end

      // The output register holds one word; a word finishing while it is stalled is lost.
      if (load) begin
         dout_d       = sreg_shift;
         dout_valid_d = 1'b1;
      end else if (dout_valid_q && bus.dout_ready) begin
         dout_valid_d = 1'b0;
      end

      if (complete && dout_valid_q && !bus.dout_ready) begin
         overrun_d = 1'b1;
      end
   end

   assign bus.dout       = dout_q;
   assign bus.dout_valid = dout_valid_q;
   assign bus.busy       = (state_q == SHIFT);
   assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_shift_deserializer.sv
// Drives identical stimulus into an MSB-first and an LSB-first deserializer and
// checks both against a queue-based frame model every cycle.
module tb_shift_deserializer;
   localparam int N = 4;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   shift_deserializer_if #(.N(N)) bm ();
   shift_deserializer_if #(.N(N)) bl ();

   shift_deserializer #(.N(N), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .reset(reset), .bus(bm.slave));
   shift_deserializer #(.N(N), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .reset(reset), .bus(bl.slave));

   // Model: bits of the current frame in arrival order, plus the output register.
   bit           q[$];
   bit           in_frame;
   logic [N-1:0] e_dm, e_dl;
   logic         e_v, e_ov;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model(input logic fs, input logic s, input logic sv, input logic rdy,
                        input logic rst);
      logic         comp;
      logic [N-1:0] wm, wl;
      wm = '0;
      wl = '0;
      comp = 1'b0;
      if (rst) begin
         q.delete();
         in_frame = 1'b0;
         e_dm = '0; e_dl = '0; e_v = 1'b0; e_ov = 1'b0;
      end else begin
         if (fs) begin
            q.delete();
            in_frame = 1'b1;
         end
         if (in_frame && sv) q.push_back(s);
         if (q.size() == N) begin
            comp = 1'b1;
            for (int i = 0; i < N; i++) begin
               wm[N-1-i] = q[i];
               wl[i]     = q[i];
            end
            q.delete();
            in_frame = 1'b0;
         end
         if (comp) begin
            if (e_v && !rdy) e_ov = 1'b1;
            else begin
               e_dm = wm; e_dl = wl; e_v = 1'b1;
            end
         end else if (e_v && rdy) begin
            e_v = 1'b0;
         end
      end
   endtask

   // One clock: apply inputs, advance the model, then compare both DUTs after the edge.
   task automatic cyc(input logic fs, input logic s, input logic sv, input logic rdy,
                      input logic rst = 1'b0);
      reset = rst;
      bm.frame_start = fs; bm.sin = s; bm.sin_valid = sv; bm.dout_ready = rdy;
      bl.frame_start = fs; bl.sin = s; bl.sin_valid = sv; bl.dout_ready = rdy;
      model(fs, s, sv, rdy, rst);
      @(posedge clk);
      #1;
      chk("m.dout",       bm.dout,       e_dm);
      chk("m.dout_valid", bm.dout_valid, e_v);
      chk("m.busy",       bm.busy,       in_frame);
      chk("m.overrun",    bm.overrun,    e_ov);
      chk("l.dout",       bl.dout,       e_dl);
      chk("l.dout_valid", bl.dout_valid, e_v);
      chk("l.busy",       bl.busy,       in_frame);
      chk("l.overrun",    bl.overrun,    e_ov);
   endtask

   // bits[N-1] arrives first, together with frame_start.
   task automatic frame(input logic [N-1:0] bits, input logic rdy);
      for (int i = N - 1; i >= 0; i--) cyc(i == N - 1, bits[i], 1'b1, rdy);
   endtask

   initial begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("rst.dout",    bm.dout, 0);
      chk("rst.valid",   bm.dout_valid, 0);
      chk("rst.busy",    bm.busy, 0);
      chk("rst.overrun", bm.overrun, 0);

      // Idle sin_valid without frame_start is ignored
      cyc(1'b0, 1'b1, 1'b1, 1'b1);
      chk("idle.busy", bm.busy, 0);

      // Basic frame 1,0,1,1
      cyc(1'b1, 1'b1, 1'b1, 1'b1);
      chk("f1.busy0", bm.busy, 1);
      cyc(1'b0, 1'b0, 1'b1, 1'b1);
      cyc(1'b0, 1'b1, 1'b1, 1'b1);
      chk("f1.busy2", bm.busy, 1);
      chk("f1.novalid", bm.dout_valid, 0);
      cyc(1'b0, 1'b1, 1'b1, 1'b1);
      chk("f1.m_dout", bm.dout, 4'b1011);
      chk("f1.l_dout", bl.dout, 4'b1101);
      chk("f1.valid",  bm.dout_valid, 1);
      chk("f1.idle",   bm.busy, 0);
      chk("f1.model",  e_dm, 4'b1011);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      chk("f1.onecyc", bm.dout_valid, 0);

      // Gapped frame 1,0,1,1
      cyc(1'b1, 1'b1, 1'b1, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b1, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      chk("gap.busy", bm.busy, 1);
      chk("gap.hold", bm.dout_valid, 0);
      cyc(1'b0, 1'b1, 1'b1, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b1, 1'b1, 1'b1);
      chk("gap.m_dout", bm.dout, 4'b1011);
      chk("gap.l_dout", bl.dout, 4'b1101);
      chk("gap.valid",  bm.dout_valid, 1);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);

      // Overrun: stalled consumer, second word dropped
      frame(4'b1011, 1'b0);
      frame(4'b0110, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      chk("ovr.dout",  bm.dout, 4'b1011);
      chk("ovr.valid", bm.dout_valid, 1);
      chk("ovr.flag",  bm.overrun, 1);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      chk("ovr.hs",     bm.dout_valid, 0);
      chk("ovr.sticky", bm.overrun, 1);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      chk("ovr.sticky2", bm.overrun, 1);

      // Aborted frame restarted by a second frame_start
      cyc(1'b1, 1'b1, 1'b1, 1'b1);
      cyc(1'b0, 1'b1, 1'b1, 1'b1);
      cyc(1'b1, 1'b0, 1'b0, 1'b1);
      chk("abort.busy",  bm.busy, 1);
      chk("abort.noval", bm.dout_valid, 0);
      cyc(1'b0, 1'b0, 1'b1, 1'b1);
      cyc(1'b0, 1'b1, 1'b1, 1'b1);
      chk("abort.noval2", bm.dout_valid, 0);
      cyc(1'b0, 1'b1, 1'b1, 1'b1);
      cyc(1'b0, 1'b0, 1'b1, 1'b1);
      chk("abort.m_dout", bm.dout, 4'b0110);
      chk("abort.l_dout", bl.dout, 4'b0110);
      chk("abort.valid",  bm.dout_valid, 1);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);

      // Reset mid-frame, with frame_start/sin_valid also asserted
      cyc(1'b1, 1'b1, 1'b1, 1'b1);
      cyc(1'b0, 1'b0, 1'b1, 1'b1);
      cyc(1'b0, 1'b1, 1'b1, 1'b1);
      cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      chk("rst2.busy",    bm.busy, 0);
      chk("rst2.dout",    bm.dout, 0);
      chk("rst2.valid",   bm.dout_valid, 0);
      chk("rst2.overrun", bm.overrun, 0);
      frame(4'b1001, 1'b1);
      chk("rst2.m_dout", bm.dout, 4'b1001);
      chk("rst2.l_dout", bl.dout, 4'b1001);
      chk("rst2.valid1", bm.dout_valid, 1);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
